// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray/binary helpers for both clock-domain controllers.
package fifo_pkg;

  localparam int ASIZE_DEF = 4;
  localparam int DSIZE_DEF = 8;
  localparam int PTR_MAX   = 32;

  // Binary to reflected Gray code.
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b = g;
    for (int s = 1; s < PTR_MAX; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter for a W-bit pointer.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = ASIZE_DEF + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(PTR_MAX'(gray)));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty/level status and
// a first-word-fall-through output register with a valid/ready handshake.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ASIZE    = ASIZE_DEF,
  parameter int DSIZE    = DSIZE_DEF,
  parameter int AE_LEVEL = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   s_wptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] mem_raddr,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rlevel
);

  localparam int PW = ASIZE + 1;

  logic [ASIZE:0] rbin, rbin_next, rgray_next, wbin, level_next;
  logic           load;

  fifo_gray2bin #(.W(PW)) u_wptr_g2b (
    .gray (s_wptr),
    .bin  (wbin)
  );

  // Pull a word from storage whenever the output register is free or being drained.
  assign load       = ~rempty & (~m_valid | m_ready);
  assign rbin_next  = rbin + PW'(load);
  assign rgray_next = PW'(bin2gray(PTR_MAX'(rbin_next)));
  assign level_next = wbin - rbin_next;
  assign mem_raddr  = rbin[ASIZE-1:0];

  // Read pointer and storage status; compared against the post-pop pointer so
  // status never lags a read by a cycle. A stale s_wptr only under-reports.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == s_wptr);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= PW'(AE_LEVEL));
    end
  end

  // Output register: reload on load, clear on a handshake, otherwise hold.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= mem_rdata;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: table-driven handshake sequence, directed burst/wrap/
// reset sequences and a randomized phase, all checked against a count-based model.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  bit         clk_en = 1'b1;
  logic       rrst_n;
  logic [4:0] s_wptr;
  logic [4:0] rptr;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;

  logic [7:0] mem [16];
  assign mem_rdata = mem[mem_raddr];

  always #5 rclk = clk_en ? ~rclk : 1'b0;

  fifo_rd_ctrl #(.ASIZE(4), .DSIZE(8), .AE_LEVEL(2)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .s_wptr        (s_wptr),
    .rptr          (rptr),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel)
  );

  // Model: W = words published by the writer, R = words pulled into the output
  // register (both unbounded integers); words[] is the written stream in order.
  int         nchk = 0;
  int         nfail = 0;
  int         W, R;
  bit         me, mv;
  logic [7:0] md;
  logic [7:0] words [4096];

  function automatic logic [4:0] g5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    W = 0; R = 0; me = 1'b1; mv = 1'b0; md = 8'h00;
    s_wptr = 5'd0;
  endtask

  task automatic push(input logic [7:0] d);
    mem[W % 16] = d;
    words[W] = d;
    W++;
    s_wptr = g5(W);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rempty"}, int'(rempty), int'(me));
    chk({tag, ".m_valid"}, int'(m_valid), int'(mv));
    chk({tag, ".m_data"}, int'(m_data), int'(md));
    chk({tag, ".rptr"}, int'(rptr), int'(g5(R)));
    chk({tag, ".rlevel"}, int'(rlevel), W - R);
    chk({tag, ".ralmost_empty"}, int'(ralmost_empty), int'((W - R) <= 2));
    chk({tag, ".mem_raddr"}, int'(mem_raddr), R % 16);
  endtask

  // One clock: apply ready, advance the model, then sample 1 time unit after the edge.
  task automatic cycle(input bit rdy, input string tag);
    bit ld;
    m_ready = rdy;
    ld = !me && (!mv || rdy);
    if (ld) md = words[R];
    mv = ld ? 1'b1 : (rdy ? 1'b0 : mv);
    R += int'(ld);
    me = (W == R);
    @(posedge rclk); #1;
    check_all(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rempty"}, int'(rempty), 1);
    chk({tag, ".m_valid"}, int'(m_valid), 0);
    chk({tag, ".m_data"}, int'(m_data), 0);
    chk({tag, ".rptr"}, int'(rptr), 0);
    chk({tag, ".rlevel"}, int'(rlevel), 0);
    chk({tag, ".ralmost_empty"}, int'(ralmost_empty), 1);
  endtask

  task automatic reset_dut(input string tag);
    rrst_n = 1'b0;
    m_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge rclk);
    #1 check_reset_vals({tag, ".in"});
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk); #1;
    check_reset_vals({tag, ".out"});
  endtask

  task automatic timeout(input string tag);
    nchk++;
    nfail++;
    $display("FAIL %s: got timeout expected progress", tag);
  endtask

  typedef struct {
    bit         push;
    logic [7:0] d;
    bit         rdy;
    bit         e_empty;
    bit         e_valid;
    logic [7:0] e_data;
    logic [4:0] e_rptr;
    logic [4:0] e_level;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int guard;

    // Single word, stalled downstream, then drained.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 5'd1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 5'd0};
    for (int i = 2; i < 12; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 5'd0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd1, 5'd0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd1, 5'd0};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_ready = 1'b0;
    model_reset();
    reset_dut("t1");

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].push) push(tbl[i].d);
      cycle(tbl[i].rdy, "t2.model");
      chk($sformatf("t2[%0d].rempty", i), int'(rempty), int'(tbl[i].e_empty));
      chk($sformatf("t2[%0d].m_valid", i), int'(m_valid), int'(tbl[i].e_valid));
      chk($sformatf("t2[%0d].m_data", i), int'(m_data), int'(tbl[i].e_data));
      chk($sformatf("t2[%0d].rptr", i), int'(rptr), int'(tbl[i].e_rptr));
      chk($sformatf("t2[%0d].rlevel", i), int'(rlevel), int'(tbl[i].e_level));
    end

    // Eight-word burst, ready held high.
    reset_dut("t3.rst");
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int i = 0; i < 12; i++) cycle(1'b1, "t3");
    chk("t3.final_rptr", int'(rptr), int'(5'b01100));

    // Same burst with ready toggling.
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int i = 0; i < 24; i++) cycle(i % 2 == 0, "t4");

    // Pointer wrap.
    guard = 0;
    while (R < 30 && guard < 200) begin
      if (W < 30 && W - R < 16) push(8'(W));
      cycle(1'b1, "t5a");
      guard++;
    end
    if (guard >= 200) timeout("t5a.wait");
    while (W < 35) push(8'(W));
    cycle(1'b0, "t5b");
    cycle(1'b0, "t5b");
    chk("t5.level_at_30", int'(rlevel), 5);
    chk("t5.rptr_at_30", int'(rptr), int'(5'b10001));
    guard = 0;
    while (R < 32 && guard < 20) begin
      cycle(1'b1, "t5c");
      guard++;
    end
    if (guard >= 20) timeout("t5c.wait");
    while (W - R < 16) push(8'(W));
    cycle(1'b0, "t5d");
    cycle(1'b0, "t5d");
    chk("t5.level_full", int'(rlevel), 16);
    chk("t5.ae_full", int'(ralmost_empty), 0);
    chk("t5.rptr_wrap", int'(rptr), 0);
    guard = 0;
    while ((W != R || mv) && guard < 100) begin
      cycle($urandom_range(0, 2) != 0, "t5e");
      guard++;
    end
    if (guard >= 100) timeout("t5e.drain");

    // Asynchronous reset with the clock stopped and a word held.
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) cycle(1'b0, "t6a");
    chk("t6.valid_before", int'(m_valid), 1);
    clk_en = 1'b0;
    @(negedge rclk);
    #2 rrst_n = 1'b0;
    #1 check_reset_vals("t6.async");
    chk("t6.raddr", int'(mem_raddr), 0);
    model_reset();
    #2 rrst_n = 1'b1;
    #2 clk_en = 1'b1;
    push(8'h3C);
    cycle(1'b0, "t6b");
    cycle(1'b0, "t6b");
    chk("t6.first_word", int'(m_data), 8'h3C);
    chk("t6.first_valid", int'(m_valid), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && W - R < 16) push(8'($urandom));
      cycle($urandom_range(0, 3) != 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
